// File: rtl/seq_multiplier.sv
// Sequential 32x32 shift-add multiplier, one product bit per clock, Run/Ready handshake.
// Define MULT_SIGNED_EN for two's-complement operands (magnitude multiply plus a FIX negate cycle).
module seq_multiplier (
    input  logic        clk,
    input  logic        Reset,
    input  logic        Run,
    input  logic [31:0] Multiplicand,
    input  logic [31:0] Multiplier,
    output logic [31:0] Product_hi,
    output logic [31:0] Product_lo,
    output logic        Ready
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t      state_q, state_d;
    logic [64:0] p_q, p_d;          // {C, HI, LO}
    logic [31:0] m_q, m_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] a_load, b_load;
    logic [32:0] addend, sum;

`ifdef MULT_SIGNED_EN
    logic sign_q, sign_d;
    // -2^31 maps to 0x8000_0000, which is its correct unsigned magnitude.
    assign a_load = Multiplicand[31] ? (~Multiplicand + 32'd1) : Multiplicand;
    assign b_load = Multiplier[31]   ? (~Multiplier   + 32'd1) : Multiplier;
`else
    assign a_load = Multiplicand;
    assign b_load = Multiplier;
`endif

    assign addend = p_q[0] ? {1'b0, m_q} : 33'd0;
    assign sum    = {p_q[64], p_q[63:32]} + addend;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (Run) state_d = CALC;
            CALC: if (cnt_q == 6'd31) begin
`ifdef MULT_SIGNED_EN
                state_d = FIX;
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        Ready      = (state_q == IDLE);
        Product_hi = p_q[63:32];
        Product_lo = p_q[31:0];
    end

    always_comb begin
        p_d   = p_q;
        m_d   = m_q;
        cnt_d = cnt_q;
`ifdef MULT_SIGNED_EN
        sign_d = sign_q;
`endif
        case (state_q)
            IDLE: if (Run) begin
                p_d   = {1'b0, 32'd0, b_load};
                m_d   = a_load;
                cnt_d = 6'd0;
`ifdef MULT_SIGNED_EN
                sign_d = Multiplicand[31] ^ Multiplier[31];
`endif
            end
            // Add and shift in one edge: the carry becomes the new HI[31].
            CALC: begin
                p_d   = {1'b0, sum, p_q[31:1]};
                cnt_d = cnt_q + 6'd1;
            end
`ifdef MULT_SIGNED_EN
            FIX: if (sign_q) p_d = {1'b0, ~p_q[63:0] + 64'd1};
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            p_q   <= '0;
            m_q   <= '0;
            cnt_q <= '0;
        end else begin
            p_q   <= p_d;
            m_q   <= m_d;
            cnt_q <= cnt_d;
        end
    end

`ifdef MULT_SIGNED_EN
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) sign_q <= 1'b0;
        else        sign_q <= sign_d;
    end
`endif

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: reset abort, latency, busy-Run rejection, back-to-back runs.
// Build with MULT_SIGNED_EN to exercise the signed variant.
module tb_seq_multiplier;

`ifdef MULT_SIGNED_EN
    localparam int LAT = 33;
`else
    localparam int LAT = 32;
`endif

    logic        clk   = 1'b0;
    logic        Reset = 1'b1;
    logic        Run   = 1'b0;
    logic [31:0] a     = '0;
    logic [31:0] b     = '0;
    logic [31:0] ph, pl;
    logic        rdy;

    int n_cmp = 0;
    int n_err = 0;

    seq_multiplier dut (
        .clk(clk), .Reset(Reset), .Run(Run),
        .Multiplicand(a), .Multiplier(b),
        .Product_hi(ph), .Product_lo(pl), .Ready(rdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%016h want 0x%016h", tag, got, exp);
        end
    endtask

    // Caller is at a negedge; Run is accepted at the next posedge.
    task automatic run_op(input string tag, input logic [31:0] ma, input logic [31:0] mb,
                          input logic [63:0] exp, input bit pulse);
        int k;
        bit busy_ok;
        Run = 1'b1; a = ma; b = mb;
        @(posedge clk); @(negedge clk);
        Run = 1'b0; a = ~ma; b = mb ^ 32'h5a5a_a5a5;
        busy_ok = (rdy == 1'b0);
        k = 0;
        while (!rdy && k < LAT + 10) begin
            @(posedge clk); @(negedge clk);
            k++;
            Run = (pulse && (k == 5 || k == 20));
            if (k == 12) begin a = 32'hdead_beef; b = 32'h0bad_f00d; end
        end
        Run = 1'b0;
        chk({tag, ".busy"}, {63'd0, busy_ok}, 64'd1);
        chk({tag, ".lat"}, 64'(k), 64'(LAT));
        chk(tag, {ph, pl}, exp);
    endtask

    logic [31:0] oa [3];
    logic [31:0] ob [3];
    logic [63:0] oe [3];

    initial begin
        #2 Reset = 1'b0;
        #10;
        chk("reset.prod", {ph, pl}, 64'd0);
        chk("reset.ready", 64'(rdy), 64'd1);
        @(negedge clk) Reset = 1'b1;

        // Abort an operation after the counter reaches 10.
        Run = 1'b1; a = 32'h1234_5678; b = 32'h0000_00ff;
        @(posedge clk); @(negedge clk);
        Run = 1'b0;
        repeat (10) @(negedge clk);
        chk("midcalc.busy", 64'(rdy), 64'd0);
        Reset = 1'b0;
        #1;
        chk("abort.prod", {ph, pl}, 64'd0);
        chk("abort.ready", 64'(rdy), 64'd1);
        @(negedge clk);
        Reset = 1'b1;
        chk("release.prod", {ph, pl}, 64'd0);
        run_op("3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000f, 1'b0);

        run_op("0xN", 32'd0, 32'h1234_5678, 64'd0, 1'b1);
        @(negedge clk); @(negedge clk);
        chk("0xN.hold", {ph, pl}, 64'd0);
        chk("0xN.idle", 64'(rdy), 64'd1);
        run_op("Nx1", 32'h1234_5678, 32'd1, 64'h0000_0000_1234_5678, 1'b1);
        @(negedge clk); @(negedge clk);
        chk("Nx1.hold", {ph, pl}, 64'h0000_0000_1234_5678);

`ifdef MULT_SIGNED_EN
        run_op("m3x5", 32'hffff_fffd, 32'd5, 64'hffff_ffff_ffff_fff1, 1'b0);
        run_op("minxmin", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0);
        run_op("7xm1", 32'd7, 32'hffff_ffff, 64'hffff_ffff_ffff_fff9, 1'b0);
        run_op("m3xm5", 32'hffff_fffd, 32'hffff_fffb, 64'd15, 1'b0);
        for (int i = 0; i < 1000; i++) begin
            logic [31:0] ra, rb;
            logic signed [63:0] sa, sb;
            ra = $urandom; rb = $urandom;
            sa = $signed(ra); sb = $signed(rb);
            run_op("rand", ra, rb, sa * sb, 1'b0);
        end
`else
        run_op("ffxff", 32'hffff_ffff, 32'hffff_ffff, 64'hffff_fffe_0000_0001, 1'b0);
        run_op("8x8", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0);
        run_op("ffx2", 32'hffff_ffff, 32'd2, 64'h0000_0001_ffff_fffe, 1'b0);
`endif

        // Run held high: each product uses only the operands present at its accept edge.
        oa[0] = 32'd6;      ob[0] = 32'd7;      oe[0] = 64'd42;
        oa[1] = 32'h1000;   ob[1] = 32'h1000;   oe[1] = 64'h0000_0000_0100_0000;
        oa[2] = 32'h1234_5678; ob[2] = 32'h10;  oe[2] = 64'h0000_0001_2345_6780;
        Run = 1'b1; a = oa[0]; b = ob[0];
        for (int i = 0; i < 3; i++) begin
            int k;
            @(posedge clk); @(negedge clk);
            chk($sformatf("held%0d.busy", i), 64'(rdy), 64'd0);
            a = 32'hcafe_f00d; b = 32'h7777_1111;
            k = 0;
            while (!rdy && k < LAT + 10) begin
                if (k == LAT - 3 && i < 2) begin a = oa[i+1]; b = ob[i+1]; end
                @(posedge clk); @(negedge clk);
                k++;
            end
            chk($sformatf("held%0d.lat", i), 64'(k), 64'(LAT));
            chk($sformatf("held%0d", i), {ph, pl}, oe[i]);
            if (i == 2) Run = 1'b0;
        end
        @(posedge clk); @(negedge clk);
        chk("held.stop", 64'(rdy), 64'd1);
        chk("held.keep", {ph, pl}, oe[2]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Sequential 32x32 shift-add multiplier. It is the multiply-side counterpart of the restoring divider in the same arithmetic datapath: one operand pair in, one 64-bit product out, one product bit resolved per clock. It uses the same Run/Ready handshake as the divider, so a shared control wrapper can drive either unit with identical sequencing.

## Interface
- No parameters. Width is fixed at 32-bit operands and a 64-bit product.
- clk  input  1  Sole clock. All state updates on the rising edge.
- Reset  input  1  Asynchronous, active-low reset. Asserting it (0) clears all state immediately.
- Run  input  1  Start request. Sampled only in IDLE.
- Multiplicand  input  32  Operand A. Captured on the accepted Run edge.
- Multiplier  input  32  Operand B. Captured on the accepted Run edge.
- Product_hi  output  32  Upper half of the product.
- Product_lo  output  32  Lower half of the product.
- Ready  output  1  1 = idle, and the product is valid (or cleared after reset). 0 = busy.

## Operation
- Internal state:
  - 65-bit product register P = {C, HI, LO}.
  - 32-bit multiplicand register M.
  - 6-bit iteration counter.
  - FSM with states IDLE, CALC and, with the macro defined, FIX.
- Reset (Reset=0), from any state including mid-CALC:
  - The operation is aborted.
  - P=0, M=0, counter=0, state=IDLE.
  - Product_hi=0, Product_lo=0, Ready=1.
- IDLE:
  - Ready=1. Outputs hold the last product.
  - If Run=1 at an edge: M<=Multiplicand, LO<=Multiplier, HI<=0, C<=0, counter<=0, and the state goes to CALC.
- CALC, one iteration per edge:
  - If LO[0]=1, then {C,HI} = HI + M (33-bit sum). Otherwise {C,HI} is unchanged.
  - P is then logically shifted right by 1 in the same edge: the new HI[31] is C, and C clears.
  - counter increments.
  - After the iteration with counter=31, the state goes to IDLE (or to FIX when the macro is defined).
- Run is ignored outside IDLE. Operand inputs may change freely while busy.
- Run held continuously high starts a new operation on every edge where the state is IDLE. There is exactly one IDLE cycle (Ready=1) between back-to-back operations.
- The product is exact modulo 2^64. No overflow is possible in unsigned mode.
- Product_hi and Product_lo are driven directly from HI and LO. Intermediate values are visible while Ready=0 and are don't-care.

## Timing
- Run is accepted at edge N. Ready falls after edge N.
- Iterations occur at edges N+1 through N+32.
- Without the macro: Ready=1 and the product is valid after edge N+32 (latency 32 cycles after the load edge).
- With the macro: the FIX cycle is at edge N+33, and Ready=1 and the product is valid after edge N+33.
- Earliest next accept: edge N+33 without the macro, N+34 with it.
- Reset assertion takes effect asynchronously.
- Reset deassertion: the first Run can be accepted on the first edge after deassertion.

## Configuration
- MULT_SIGNED_EN defined:
  - Operands are two's complement.
  - On load, M and LO receive the absolute values of the operands. The result sign (XOR of the operand MSBs) is stored in a flag.
  - CALC then runs unchanged on the magnitudes.
  - FIX, one cycle: if the sign flag is 1, the product is negated as a 64-bit two's-complement value. The state then goes to IDLE.
  - |−2^31| is treated as the unsigned value 2^31, so (−2^31)×(−2^31)=0x4000_0000_0000_0000.
- MULT_SIGNED_EN undefined:
  - Operands are unsigned.
  - No FIX state and no sign flag.

## Test plan
- Reset low mid-CALC (counter=10), then released → outputs 0, Ready=1 immediately. Next Run with 3×5 → 0x0000_0000_0000_000F.
- Unsigned 0xFFFF_FFFF×0xFFFF_FFFF → Product_hi=0xFFFF_FFFE, Product_lo=0x0000_0001. Ready rises exactly 32 cycles after the load edge.
- 0×0x1234_5678 and 0x1234_5678×1 → 0 and 0x0000_0000_1234_5678. Run pulses while busy are ignored, and the results are unchanged.
- Run held high for three operations, with operand changes mid-CALC → each product uses only the operands at its accept edge. Ready is high for exactly one cycle between operations.
- MULT_SIGNED_EN: −3×5 → 0xFFFF_FFFF_FFFF_FFF1. −2^31×−2^31 → 0x4000_0000_0000_0000. Latency is 33 cycles.
- MULT_SIGNED_EN: 7×−1 → 0xFFFF_FFFF_FFFF_FFF9. Compare against a reference model over 1000 random signed pairs → zero mismatches.
